// File: rtl/servo_pkg.sv
// Shared servo constants, FSM encoding and angle-to-pulse conversion,
// common to the slew controller and the PWM stage.
package servo_pkg;

    localparam int TICKS_PER_US = 25;
    localparam int FRAME_TICKS  = 20_000 * TICKS_PER_US;
    localparam int MIN_US       = 650;
    localparam int MAX_US       = 2600;
    localparam int MID_US       = 1625;
    localparam int STEP_US      = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RAMP = 2'd2
    } servo_state_e;

    function automatic logic [7:0] clamp_deg(input logic [7:0] deg);
        return (deg > 8'd180) ? 8'd180 : deg;
    endfunction

    // Truncating conversion; 32-bit intermediates hold 180 * span comfortably.
    function automatic logic [31:0] deg_to_us(input logic [7:0] deg,
                                              input int min_us,
                                              input int max_us);
        return 32'(min_us) + (32'(deg) * 32'(max_us - min_us)) / 32'd180;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter; frame_tick marks the last cycle of each frame.
module servo_frame_timer #(
    parameter int FRAME_TICKS = servo_pkg::FRAME_TICKS
) (
    input  logic CLK,
    input  logic RST_N,
    output logic frame_tick
);

    localparam int            CW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign frame_tick = (count == LAST);

endmodule

// File: rtl/servo_slew_ctrl.sv
// Servo slew-rate limiter: accepts a target angle and walks the pulse width
// toward it by at most STEP_US per frame.
module servo_slew_ctrl #(
    parameter int TICKS_PER_US = servo_pkg::TICKS_PER_US,
    parameter int FRAME_TICKS  = 20_000 * TICKS_PER_US,
    parameter int MIN_US       = servo_pkg::MIN_US,
    parameter int MAX_US       = servo_pkg::MAX_US,
    parameter int STEP_US      = servo_pkg::STEP_US
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_deg,
    output logic        cmd_ready,
    output logic [31:0] control,
    output logic        busy,
    output logic        frame_tick
);

    import servo_pkg::*;

    servo_state_e state, state_nx;
    logic [7:0]   deg_q, deg_nx;
    logic [31:0]  target, target_nx, control_nx, gap;
    logic         accept;

    servo_frame_timer #(.FRAME_TICKS(FRAME_TICKS)) u_timer (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .frame_tick (frame_tick)
    );

    assign cmd_ready = (state != LOAD);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && (state != LOAD);
    assign gap       = (target >= control) ? target - control : control - target;

    always_comb begin
        state_nx   = state;
        deg_nx     = deg_q;
        target_nx  = target;
        control_nx = control;
        case (state)
            IDLE: begin
                if (accept) begin
                    deg_nx   = clamp_deg(cmd_deg);
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                target_nx = deg_to_us(deg_q, MIN_US, MAX_US);
                state_nx  = RAMP;
            end
            RAMP: begin
                // A retarget wins over the frame step in the same cycle.
                if (accept) begin
                    deg_nx   = clamp_deg(cmd_deg);
                    state_nx = LOAD;
                end else if (frame_tick) begin
                    if (gap <= 32'(STEP_US)) begin
                        control_nx = target;
                        state_nx   = IDLE;
                    end else if (target > control) begin
                        control_nx = control + 32'(STEP_US);
                    end else begin
                        control_nx = control - 32'(STEP_US);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deg_q   <= 8'd90;
            target  <= 32'(MID_US);
            control <= 32'(MID_US);
        end else begin
            deg_q   <= deg_nx;
            target  <= target_nx;
            control <= control_nx;
        end
    end

endmodule

// File: doc/servo_slew_ctrl.md
SERVO_SLEW_CTRL -- requirements
Module: servo_slew_ctrl

Interface
REQ-001 Parameter TICKS_PER_US, 25: CLK cycles per microsecond.
REQ-002 Parameter FRAME_TICKS, 500000: CLK cycles per 20 ms servo frame.
REQ-003 Parameter MIN_US, 650: pulse width at 0 degrees, in µs.
REQ-004 Parameter MAX_US, 2600: pulse width at 180 degrees, in µs.
REQ-005 Parameter STEP_US, 10: maximum change of control per frame, in µs.
REQ-006 CLK  input  1  single system clock, 25 MHz, rising edge.
REQ-007 RST_N  input  1  reset, asynchronous, active-low.
REQ-008 cmd_valid  input  1  target angle command is valid.
REQ-009 cmd_deg  input  8  target angle in degrees, unsigned.
REQ-010 cmd_ready  output  1  block can accept a command.
REQ-011 control  output  32  commanded pulse width in µs, fed to the PWM stage.
REQ-012 busy  output  1  control has not yet reached the target.
REQ-013 frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 The frame counter SHALL count 0..FRAME_TICKS-1 and then wrap to 0; frame_tick SHALL be 1 exactly in the cycle where the count equals FRAME_TICKS-1.
REQ-015 The FSM SHALL have three states: IDLE, LOAD, RAMP; busy SHALL be 1 in LOAD and RAMP.
REQ-016 cmd_ready SHALL be 1 in IDLE and RAMP and 0 in LOAD.
REQ-017 A command SHALL be accepted when cmd_valid and cmd_ready are both 1 on a rising edge; accepting a command SHALL move the FSM to LOAD from IDLE or from RAMP (retarget).
REQ-018 Before conversion, cmd_deg values above 180 SHALL be clamped to 180.
REQ-019 In LOAD the target SHALL be registered as MIN_US + (deg*(MAX_US-MIN_US))/180 using truncating integer division and at least 20-bit intermediates; the FSM SHALL then move to RAMP on the next cycle.
REQ-020 In RAMP, on a frame_tick cycle:
- if |target-control| <= STEP_US, control SHALL load target and the FSM SHALL go to IDLE;
- otherwise control SHALL move by STEP_US toward target.
REQ-021 control SHALL change only in RAMP on frame_tick cycles; it SHALL never leave the range [MIN_US, MAX_US].
REQ-022 If a command is accepted in the same cycle as frame_tick while in RAMP, the accept SHALL take priority and control SHALL not step in that cycle.
REQ-023 Retargeting SHALL NOT reset the frame counter; ramping SHALL continue from the current value of control.
REQ-024 In IDLE, cmd_valid=0 SHALL leave all state unchanged; the frame counter SHALL run in every state.

Reset
REQ-025 While RST_N=0, asynchronously:
- state = IDLE, frame counter = 0, target = 1625;
- control = 1625 (90 degrees), busy = 0, frame_tick = 0, cmd_ready = 1.
REQ-026 Reset asserted mid-RAMP SHALL abandon the ramp immediately; the first command after release SHALL be handled normally.

Structure
REQ-027 MIN_US, MAX_US, the 90-degree value 1625, TICKS_PER_US, FRAME_TICKS, and the state encoding SHALL live in a shared package servo_pkg, which is also used by the PWM stage.
REQ-028 The frame counter SHALL be a sub-module, servo_frame_timer, with ports CLK, RST_N, and frame_tick.

Verification
REQ-029 Reset release, no command -> control=1625, busy=0, cmd_ready=1; frame_tick period exactly 500000 cycles.
REQ-030 cmd_deg=0 after reset -> control=1615 after the 1st frame_tick, 655 after the 97th, 650 after the 98th; busy falls on the 98th.
REQ-031 cmd_deg=45 -> target 1137; cmd_deg=90 -> target 1625, FSM to IDLE at the first frame_tick with control unchanged.
REQ-032 cmd_deg=200 -> clamped; control ramps to exactly 2600 and never exceeds it.
REQ-033 Ramping toward 0 deg, retarget to 180 in a frame_tick cycle -> no step that frame, then +10 per frame; cmd_ready=0 for exactly one cycle.
REQ-034 RST_N pulsed low mid-ramp -> control=1625 and state IDLE asynchronously; the next command ramps correctly.
